// File: rtl/edge_bitmap_packer.sv
// Packs the binary edge map from the Canny pipeline into 16-pixel words, buffers them in a
// first-word-fall-through FIFO and reports a per-frame edge count and overflow flag.
module edge_bitmap_packer #(
    parameter int IMG_W      = 632,
    parameter int IMG_H      = 504,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_fun,
    input  logic        b_fval_sync,
    input  logic        b_lval_sync,
    input  logic [15:0] in_data,
    output logic [15:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_eol,
    output logic        m_eof,
    output logic [19:0] edge_cnt,
    output logic        edge_cnt_vld,
    output logic        ovf
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int RW = $clog2(IMG_H) + 1;
    localparam int CW = $clog2(IMG_W + 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);
    localparam logic [CW-1:0] LINE_PIX = CW'(IMG_W);

    typedef enum logic [1:0] {IDLE, ARMED, ACTIVE} state_t;

    state_t        state_q, state_d;
    logic          fval_prev_q, fval_prev_d;
    logic          lval_prev_q, lval_prev_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [15:0]   sr_q, sr_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [19:0]   ecnt_q, ecnt_d;
    logic [15:0]   word_q, word_d;
    logic          push_q, push_d;
    logic          push_tag_q, push_tag_d;
    logic          push_eol_q, push_eol_d;
    logic          push_eof_q, push_eof_d;
    logic [19:0]   edge_cnt_q, edge_cnt_d;
    logic          edge_cnt_vld_q, edge_cnt_vld_d;
    logic          ovf_q, ovf_d;
    logic [AW:0]   wptr_q, wptr_d;
    logic [AW:0]   rptr_q, rptr_d;
    logic [17:0]   mem [FIFO_DEPTH];

    logic        active, pix, edge_bit;
    logic        fval_rise, fval_fall, lval_rise, line_end, frame_end;
    logic        empty, full, pop, wr_en, drop, wr_eol, wr_eof;
    logic [17:0] head;
    logic [15:0] packed_bits;

    assign active    = (state_q == ACTIVE);
    assign edge_bit  = |in_data;
    assign fval_rise = ~fval_prev_q & b_fval_sync;
    assign fval_fall = fval_prev_q & ~b_fval_sync;
    assign lval_rise = ~lval_prev_q & b_lval_sync;
    // Pixels beyond IMG_W in one line are ignored so a malformed line cannot corrupt the row
    assign pix       = active & ~b_fval_sync & ~b_lval_sync & (col_q < LINE_PIX);
    assign line_end  = active & lval_rise;
    assign frame_end = active & fval_rise;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop   = ~empty & m_ready;
    assign wr_en = push_q & (~full | pop);
    assign drop  = push_q & full & ~pop;
    // A full word is pushed the cycle after its 16th pixel, which is exactly the cycle the
    // line end shows up when that pixel was the last of the line, so it is tagged here.
    assign wr_eol = push_tag_q ? push_eol_q : line_end;
    assign wr_eof = push_tag_q ? push_eof_q : (line_end & (row_q == LAST_ROW));

    assign head         = mem[rptr_q[AW-1:0]];
    assign m_valid      = ~empty;
    assign m_data       = empty ? 16'h0000 : head[15:0];
    assign m_eol        = ~empty & head[16];
    assign m_eof        = ~empty & head[17];
    assign edge_cnt     = edge_cnt_q;
    assign edge_cnt_vld = edge_cnt_vld_q;
    assign ovf          = ovf_q;

    always_comb begin
        state_d        = state_q;
        fval_prev_d    = b_fval_sync;
        lval_prev_d    = b_lval_sync;
        bitcnt_d       = bitcnt_q;
        sr_d           = sr_q;
        col_d          = col_q;
        row_d          = row_q;
        ecnt_d         = ecnt_q;
        word_d         = word_q;
        push_d         = 1'b0;
        push_tag_d     = 1'b0;
        push_eol_d     = 1'b0;
        push_eof_d     = 1'b0;
        edge_cnt_d     = edge_cnt_q;
        edge_cnt_vld_d = 1'b0;
        ovf_d          = ovf_q;
        packed_bits    = sr_q;
        wptr_d         = wptr_q + (AW+1)'(wr_en);
        rptr_d         = rptr_q + (AW+1)'(pop);

        case (state_q)
            IDLE: begin
                if (b_fval_sync) state_d = ARMED;
            end
            ARMED: begin
                if (fval_fall && en_fun) begin
                    state_d  = ACTIVE;
                    bitcnt_d = 4'd0;
                    sr_d     = 16'h0000;
                    col_d    = '0;
                    row_d    = '0;
                    ecnt_d   = 20'd0;
                    ovf_d    = 1'b0;
                end
            end
            ACTIVE: begin
                if (fval_rise) state_d = ARMED;
            end
            default: state_d = IDLE;
        endcase

        if (pix) begin
            packed_bits[bitcnt_q] = edge_bit;
            col_d = col_q + CW'(1);
            if (edge_bit && (ecnt_q != 20'hFFFFF)) ecnt_d = ecnt_q + 20'd1;
            if (bitcnt_q == 4'd15) begin
                word_d   = packed_bits;
                push_d   = 1'b1;
                sr_d     = 16'h0000;
                bitcnt_d = 4'd0;
            end else begin
                sr_d     = packed_bits;
                bitcnt_d = bitcnt_q + 4'd1;
            end
        end

        // Line end is handled before frame end so a simultaneous rise still tags eol/eof
        if (line_end) begin
            col_d = '0;
            row_d = row_q + RW'(1);
            if (bitcnt_q != 4'd0) begin
                word_d     = sr_q;
                push_d     = 1'b1;
                push_tag_d = 1'b1;
                push_eol_d = 1'b1;
                push_eof_d = (row_q == LAST_ROW);
                sr_d       = 16'h0000;
                bitcnt_d   = 4'd0;
            end
        end

        if (frame_end) begin
            edge_cnt_d     = ecnt_q;
            edge_cnt_vld_d = 1'b1;
        end

        if (drop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q        <= IDLE;
            fval_prev_q    <= 1'b1;
            lval_prev_q    <= 1'b1;
            bitcnt_q       <= 4'd0;
            sr_q           <= 16'h0000;
            col_q          <= '0;
            row_q          <= '0;
            ecnt_q         <= 20'd0;
            word_q         <= 16'h0000;
            push_q         <= 1'b0;
            push_tag_q     <= 1'b0;
            push_eol_q     <= 1'b0;
            push_eof_q     <= 1'b0;
            edge_cnt_q     <= 20'd0;
            edge_cnt_vld_q <= 1'b0;
            ovf_q          <= 1'b0;
            wptr_q         <= '0;
            rptr_q         <= '0;
        end else begin
            state_q        <= state_d;
            fval_prev_q    <= fval_prev_d;
            lval_prev_q    <= lval_prev_d;
            bitcnt_q       <= bitcnt_d;
            sr_q           <= sr_d;
            col_q          <= col_d;
            row_q          <= row_d;
            ecnt_q         <= ecnt_d;
            word_q         <= word_d;
            push_q         <= push_d;
            push_tag_q     <= push_tag_d;
            push_eol_q     <= push_eol_d;
            push_eof_q     <= push_eof_d;
            edge_cnt_q     <= edge_cnt_d;
            edge_cnt_vld_q <= edge_cnt_vld_d;
            ovf_q          <= ovf_d;
            wptr_q         <= wptr_d;
            rptr_q         <= rptr_d;
        end
    end

    // Storage needs no reset: the pointers alone define what is valid
    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr_q[AW-1:0]] <= {wr_eof, wr_eol, word_q};
    end

endmodule

// File: tb/tb_edge_bitmap_packer.sv
// Scoreboard bench for edge_bitmap_packer: directed frames push hand-computed words into a
// queue, and a monitor pops and compares on every accepted output transfer.
module tb_edge_bitmap_packer;
    localparam int IMG_W = 632;
    localparam int IMG_H = 3;
    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en_fun = 1'b1;
    logic        fval = 1'b1;
    logic        lval = 1'b1;
    logic [15:0] in_data = 16'h0000;
    logic        m_ready = 1'b1;
    logic [15:0] m_data;
    logic        m_valid, m_eol, m_eof, edge_cnt_vld, ovf;
    logic [19:0] edge_cnt;

    int          n_vec = 0;
    int          n_err = 0;
    int          pulses = 0;
    int          base = 0;
    logic [19:0] last_cnt = 20'd0;
    logic [17:0] exp_q[$];
    logic [17:0] mon_e;

    always #5 clk = ~clk;

    edge_bitmap_packer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst), .en_fun(en_fun), .b_fval_sync(fval), .b_lval_sync(lval),
        .in_data(in_data), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_eol(m_eol), .m_eof(m_eof), .edge_cnt(edge_cnt), .edge_cnt_vld(edge_cnt_vld),
        .ovf(ovf)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 0: all 0xFFFF, 1: alternating 0/nonzero starting with 0, 2: one edge per 16-pixel block
    function automatic logic [15:0] pix_val(input int pat, input int i);
        case (pat)
            0:       return 16'hFFFF;
            1:       return (i % 2 == 1) ? 16'h0100 : 16'h0000;
            2:       return ((i % 16) == ((i / 16) % 16)) ? 16'h0004 : 16'h0000;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic expect_word(input logic [15:0] d, input logic eol, input logic eof);
        exp_q.push_back({eof, eol, d});
    endtask

    task automatic send_line(input int pat, input int len, input bit close_frame,
                             input bit lat_chk, input int exp_cnt);
        for (int i = 0; i < len; i++) begin
            lval    = 1'b0;
            in_data = pix_val(pat, i);
            tick();
            if (lat_chk && i == 15) chk("latency_before", m_valid, 0);
            if (lat_chk && i == 16) chk("latency_first_word", m_valid, 1);
        end
        in_data = 16'h0000;
        lval    = 1'b1;
        if (close_frame) fval = 1'b1;
        tick();
        if (close_frame) begin
            chk("simul_edge_cnt_vld", edge_cnt_vld, 1);
            chk("simul_edge_cnt", edge_cnt, exp_cnt);
        end
        tick();
    endtask

    task automatic frame_start();
        fval = 1'b1;
        tick();
        tick();
        fval = 1'b0;
        tick();
        tick();
    endtask

    task automatic frame_end();
        fval = 1'b1;
        tick();
        tick();
        tick();
    endtask

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_word: got 0x%05h, expected no word",
                         {m_eof, m_eol, m_data});
            end else begin
                mon_e = exp_q.pop_front();
                chk("word", {14'b0, m_eof, m_eol, m_data}, {14'b0, mon_e});
            end
        end
        if (edge_cnt_vld) begin
            pulses++;
            last_cnt = edge_cnt;
        end
    end

    initial begin
        tick();
        tick();
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_eol", m_eol, 0);
        chk("rst_m_eof", m_eof, 0);
        chk("rst_edge_cnt", edge_cnt, 0);
        chk("rst_edge_cnt_vld", edge_cnt_vld, 0);
        chk("rst_ovf", ovf, 0);
        rst = 1'b0;
        tick();

        // Full frame of all-edge pixels, 40-pixel lines
        frame_start();
        base = pulses;
        for (int l = 0; l < IMG_H; l++) begin
            expect_word(16'hFFFF, 1'b0, 1'b0);
            expect_word(16'hFFFF, 1'b0, 1'b0);
            expect_word(16'h00FF, 1'b1, l == IMG_H - 1);
            send_line(0, 40, 1'b0, l == 0, 0);
        end
        frame_end();
        chk("full_vld_pulses", pulses - base, 1);
        chk("full_edge_cnt", last_cnt, 120);
        chk("full_ovf", ovf, 0);

        // Alternating pattern; exact 32-pixel line puts eol on a completed word
        frame_start();
        base = pulses;
        expect_word(16'hAAAA, 1'b0, 1'b0);
        expect_word(16'hAAAA, 1'b0, 1'b0);
        expect_word(16'h00AA, 1'b1, 1'b0);
        send_line(1, 40, 1'b0, 1'b0, 0);
        expect_word(16'hAAAA, 1'b0, 1'b0);
        expect_word(16'hAAAA, 1'b1, 1'b0);
        send_line(1, 32, 1'b0, 1'b0, 0);
        expect_word(16'h000A, 1'b1, 1'b1);
        send_line(1, 5, 1'b0, 1'b0, 0);
        frame_end();
        chk("alt_vld_pulses", pulses - base, 1);
        chk("alt_edge_cnt", last_cnt, 38);

        // Consumer stalled for a full-width line: first DEPTH words kept, rest dropped
        m_ready = 1'b0;
        frame_start();
        base = pulses;
        for (int k = 0; k < DEPTH; k++) expect_word(16'h0001 << k, 1'b0, 1'b0);
        send_line(2, IMG_W, 1'b0, 1'b0, 0);
        chk("stall_ovf", ovf, 1);
        for (int c = 0; c < 4; c++) begin
            chk("stall_m_valid", m_valid, 1);
            chk("stall_m_data_held", m_data, 16'h0001);
            tick();
        end
        m_ready = 1'b1;
        for (int l = 1; l < IMG_H; l++) begin
            expect_word(16'hFFFF, 1'b0, 1'b0);
            expect_word(16'hFFFF, 1'b0, 1'b0);
            expect_word(16'h00FF, 1'b1, l == IMG_H - 1);
            send_line(0, 40, 1'b0, 1'b0, 0);
        end
        frame_end();
        chk("stall_vld_pulses", pulses - base, 1);
        chk("stall_edge_cnt", last_cnt, 120);
        chk("stall_ovf_held", ovf, 1);

        // Disabled frame produces nothing
        en_fun = 1'b0;
        frame_start();
        base = pulses;
        send_line(0, 40, 1'b0, 1'b0, 0);
        send_line(0, 40, 1'b0, 1'b0, 0);
        frame_end();
        chk("dis_vld_pulses", pulses - base, 0);
        chk("dis_m_valid", m_valid, 0);

        // Re-enabled; last line's lval and fval rise together
        en_fun = 1'b1;
        frame_start();
        chk("ovf_cleared", ovf, 0);
        base = pulses;
        expect_word(16'hAAAA, 1'b0, 1'b0);
        expect_word(16'hAAAA, 1'b0, 1'b0);
        expect_word(16'h00AA, 1'b1, 1'b0);
        send_line(1, 40, 1'b0, 1'b0, 0);
        expect_word(16'hFFFF, 1'b0, 1'b0);
        expect_word(16'hFFFF, 1'b0, 1'b0);
        expect_word(16'h00FF, 1'b1, 1'b0);
        send_line(0, 40, 1'b0, 1'b0, 0);
        expect_word(16'hFFFF, 1'b0, 1'b0);
        expect_word(16'h000F, 1'b1, 1'b1);
        send_line(0, 20, 1'b1, 1'b0, 80);
        tick();
        chk("simul_vld_pulses", pulses - base, 1);

        // Reset mid-line with fval low: silent until a full fval high-to-low
        for (int c = 0; c < 10; c++) tick();
        frame_start();
        base = pulses;
        for (int i = 0; i < 10; i++) begin
            lval    = 1'b0;
            in_data = 16'hFFFF;
            tick();
        end
        rst = 1'b1;
        tick();
        chk("midrst_m_valid", m_valid, 0);
        chk("midrst_edge_cnt", edge_cnt, 0);
        chk("midrst_ovf", ovf, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        in_data = 16'h0000;
        lval    = 1'b1;
        tick();
        send_line(0, 40, 1'b0, 1'b0, 0);
        chk("midrst_silent", m_valid, 0);
        frame_end();
        chk("midrst_vld_pulses", pulses - base, 0);
        frame_start();
        for (int l = 0; l < IMG_H; l++) begin
            expect_word(16'hAAAA, 1'b0, 1'b0);
            expect_word(16'hAAAA, 1'b0, 1'b0);
            expect_word(16'h00AA, 1'b1, l == IMG_H - 1);
            send_line(1, 40, 1'b0, 1'b0, 0);
        end
        frame_end();
        chk("after_rst_vld_pulses", pulses - base, 1);
        chk("after_rst_edge_cnt", last_cnt, 60);

        for (int c = 0; c < 200 && exp_q.size() != 0; c++) tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
